// File: rtl/multififo_write_arbiter.sv
// Round-robin write arbiter in front of a multi-port FIFO. One producer bundle is
// mapped onto the FIFO write slots at a time, and a partly written bundle keeps the grant.
module multififo_write_arbiter #(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 32,
  parameter int REQ_NUM  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [REQ_NUM-1:0]                  req_valid,
  input  logic [REQ_NUM*PORT_NUM-1:0]         req_mask,
  input  logic [REQ_NUM*PORT_NUM*WIDTH-1:0]   req_data,
  output logic [REQ_NUM*PORT_NUM-1:0]         req_accept,
  output logic [REQ_NUM-1:0]                  req_done,
  output logic [PORT_NUM*WIDTH-1:0]           fifo_data_in,
  output logic [PORT_NUM-1:0]                 fifo_data_in_valid,
  output logic                                fifo_push,
  input  logic [PORT_NUM-1:0]                 fifo_data_in_enable,
  input  logic                                fifo_full,
  output logic [$clog2(REQ_NUM)-1:0]          grant_id,
  output logic                                locked
);
  localparam int IDW = $clog2(REQ_NUM);
  localparam int CW  = $clog2(PORT_NUM) + 1;

  logic           lock_q, lock_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [CW-1:0]  offset_q, offset_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [IDW-1:0]            sel, idx;
  logic                      grant_vld;
  logic [PORT_NUM-1:0]       sel_mask;
  logic [PORT_NUM*WIDTH-1:0] sel_data;
  logic [CW-1:0]             cnt, en, rem, n;
  logic                      push, done;

  always_comb begin
    sel       = grant_q;
    idx       = '0;
    grant_vld = 1'b0;
    if (lock_q) begin
      grant_vld = req_valid[grant_q];
    end else begin
      // scan from lowest priority up so the nearest requester after rr_ptr wins
      for (int i = REQ_NUM - 1; i >= 0; i--) begin
        idx = rr_ptr_q + IDW'(i);
        if (req_valid[idx]) begin
          sel       = idx;
          grant_vld = 1'b1;
        end
      end
    end

    sel_mask = req_mask[sel*PORT_NUM +: PORT_NUM];
    sel_data = req_data[sel*PORT_NUM*WIDTH +: PORT_NUM*WIDTH];

    cnt = '0;
    en  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      cnt = cnt + CW'(sel_mask[p]);
      en  = en + CW'(fifo_data_in_enable[p]);
    end
    rem = (cnt > offset_q) ? cnt - offset_q : '0;
    n   = grant_vld ? ((rem < en) ? rem : en) : '0;

    fifo_data_in_valid = '0;
    fifo_data_in       = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      fifo_data_in_valid[k] = (CW'(k) < n);
      if (int'(offset_q) + k < PORT_NUM)
        fifo_data_in[k*WIDTH +: WIDTH] = sel_data[(int'(offset_q) + k)*WIDTH +: WIDTH];
    end

    push = (n != '0) && !fifo_full && !flush;
    // an empty bundle completes without a push
    done = !flush && grant_vld && ((push && n == rem) || rem == '0);

    req_accept = '0;
    req_done   = '0;
    if (push) begin
      for (int e = 0; e < PORT_NUM; e++)
        if (CW'(e) >= offset_q && CW'(e) < offset_q + n)
          req_accept[int'(sel)*PORT_NUM + e] = 1'b1;
    end
    if (done) req_done[sel] = 1'b1;

    fifo_push = push;
    grant_id  = grant_vld ? sel : '0;
    locked    = lock_q && grant_vld;

    lock_d   = lock_q;
    grant_d  = grant_q;
    offset_d = offset_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      lock_d   = 1'b0;
      offset_d = '0;
      rr_ptr_d = '0;
    end else if (lock_q && !req_valid[grant_q]) begin
      lock_d   = 1'b0;
      offset_d = '0;
      rr_ptr_d = grant_q + 1'b1;
    end else if (done) begin
      lock_d   = 1'b0;
      offset_d = '0;
      rr_ptr_d = sel + 1'b1;
    end else if (push) begin
      lock_d   = 1'b1;
      grant_d  = sel;
      offset_d = offset_q + n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q   <= 1'b0;
      grant_q  <= '0;
      offset_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      lock_q   <= lock_d;
      grant_q  <= grant_d;
      offset_q <= offset_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_multififo_write_arbiter.sv
// Directed vector table plus randomized producers checked against a reference model.
module tb_multififo_write_arbiter;
  localparam int P   = 2;
  localparam int W   = 32;
  localparam int R   = 2;
  localparam int IDW = $clog2(R);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [R-1:0]     req_valid = '0;
  logic [R*P-1:0]   req_mask = '0;
  logic [R*P*W-1:0] req_data = '0;
  logic [R*P-1:0]   req_accept;
  logic [R-1:0]     req_done;
  logic [P*W-1:0]   fifo_data_in;
  logic [P-1:0]     fifo_data_in_valid;
  logic             fifo_push;
  logic [P-1:0]     fifo_data_in_enable = '0;
  logic             fifo_full = 1'b0;
  logic [IDW-1:0]   grant_id;
  logic             locked;

  int n_chk  = 0;
  int n_fail = 0;

  multififo_write_arbiter #(.PORT_NUM(P), .WIDTH(W), .REQ_NUM(R)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_mask(req_mask), .req_data(req_data),
    .req_accept(req_accept), .req_done(req_done),
    .fifo_data_in(fifo_data_in), .fifo_data_in_valid(fifo_data_in_valid),
    .fifo_push(fifo_push), .fifo_data_in_enable(fifo_data_in_enable),
    .fifo_full(fifo_full), .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [R-1:0]   rv;
    logic [R*P-1:0] m;
    logic [P-1:0]   en;
    logic           full;
    logic           fl;
    logic           push;
    logic [P-1:0]   vld;
    logic [R*P-1:0] acc;
    logic [R-1:0]   done;
    logic [IDW-1:0] gid;
    logic           lk;
    logic [W-1:0]   d0;
  } vec_t;

  vec_t tbl[24];

  // Reference model: bundle progress kept as plain integers
  int m_lock, m_gr, m_off, m_rr;
  int e_sel, e_n, e_rem;
  logic           e_push;
  logic [P-1:0]   e_vld;
  logic [R*P-1:0] e_acc;
  logic [R-1:0]   e_done;
  logic [IDW-1:0] e_gid;
  logic           e_lk;

  task automatic model_reset();
    m_lock = 0; m_gr = 0; m_off = 0; m_rr = 0;
  endtask

  task automatic model_eval();
    int cnt, en;
    e_sel = -1;
    if (m_lock != 0) begin
      if (req_valid[m_gr]) e_sel = m_gr;
    end else begin
      for (int i = 0; i < R; i++)
        if (e_sel < 0 && req_valid[(m_rr + i) % R]) e_sel = (m_rr + i) % R;
    end
    e_push = 1'b0; e_vld = '0; e_acc = '0; e_done = '0; e_gid = '0; e_lk = 1'b0;
    e_n = 0; e_rem = 0;
    if (e_sel >= 0) begin
      cnt   = $countones(req_mask[e_sel*P +: P]);
      en    = $countones(fifo_data_in_enable);
      e_rem = cnt - m_off;
      e_n   = (e_rem < en) ? e_rem : en;
      for (int k = 0; k < e_n; k++) e_vld[k] = 1'b1;
      e_push = (e_n > 0) && !fifo_full && !flush;
      if (e_push)
        for (int k = 0; k < e_n; k++) e_acc[e_sel*P + m_off + k] = 1'b1;
      if (!flush && ((e_push && e_n == e_rem) || e_rem == 0)) e_done[e_sel] = 1'b1;
      e_gid = IDW'(e_sel);
      e_lk  = (m_lock != 0);
    end
  endtask

  task automatic model_commit();
    if (flush) begin
      m_lock = 0; m_off = 0; m_rr = 0;
    end else if (m_lock != 0 && !req_valid[m_gr]) begin
      m_lock = 0; m_off = 0; m_rr = (m_gr + 1) % R;
    end else if (e_sel >= 0 && e_done[e_sel]) begin
      m_lock = 0; m_off = 0; m_rr = (e_sel + 1) % R;
    end else if (e_push) begin
      m_lock = 1; m_gr = e_sel; m_off = m_off + e_n;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_mask = '0;
    fifo_data_in_enable = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic           have[R];
  int             bcnt[R];
  logic [P*W-1:0] bdat[R];
  int             en_cnt;

  initial begin
    tbl[0]  = '{2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 32'h0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = tbl[0];
    tbl[4]  = tbl[0];
    tbl[5]  = '{2'b11, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 4'b0011, 2'b01, 1'b0, 1'b0, 32'hD000_0000};
    tbl[6]  = '{2'b11, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 4'b1100, 2'b10, 1'b1, 1'b0, 32'hD000_0010};
    tbl[7]  = tbl[5];
    tbl[8]  = '{2'b10, 4'b1100, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 4'b1100, 2'b10, 1'b1, 1'b0, 32'hD000_0010};
    tbl[9]  = '{2'b11, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 4'b0001, 2'b00, 1'b0, 1'b0, 32'hD000_0000};
    tbl[10] = '{2'b11, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b1, 2'b01, 4'b0010, 2'b01, 1'b0, 1'b1, 32'hD000_0001};
    tbl[11] = tbl[6];
    tbl[12] = '{2'b01, 4'b0011, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 32'h0};
    tbl[13] = tbl[12];
    tbl[14] = tbl[12];
    tbl[15] = '{2'b01, 4'b0011, 2'b11, 1'b0, 1'b0, 1'b1, 2'b11, 4'b0011, 2'b01, 1'b0, 1'b0, 32'hD000_0000};
    tbl[16] = '{2'b11, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 4'b0100, 2'b00, 1'b1, 1'b0, 32'hD000_0010};
    tbl[17] = '{2'b11, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b0, 2'b01, 4'b0000, 2'b00, 1'b1, 1'b1, 32'hD000_0011};
    tbl[18] = tbl[5];
    tbl[19] = '{2'b01, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 4'b0001, 2'b00, 1'b0, 1'b0, 32'hD000_0000};
    tbl[20] = '{2'b10, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0, 32'h0};
    tbl[21] = tbl[6];
    tbl[22] = '{2'b01, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 2'b01, 1'b0, 1'b0, 32'h0};
    tbl[23] = tbl[6];

    do_reset();
    for (int r = 0; r < R; r++)
      for (int e = 0; e < P; e++)
        req_data[(r*P + e)*W +: W] = 32'hD000_0000 + 32'(r*16 + e);

    for (int i = 0; i < 24; i++) begin
      req_valid = tbl[i].rv; req_mask = tbl[i].m; fifo_data_in_enable = tbl[i].en;
      fifo_full = tbl[i].full; flush = tbl[i].fl;
      #1;
      chk($sformatf("vec%0d.push", i), 64'(fifo_push), 64'(tbl[i].push));
      chk($sformatf("vec%0d.valid", i), 64'(fifo_data_in_valid), 64'(tbl[i].vld));
      chk($sformatf("vec%0d.accept", i), 64'(req_accept), 64'(tbl[i].acc));
      chk($sformatf("vec%0d.done", i), 64'(req_done), 64'(tbl[i].done));
      chk($sformatf("vec%0d.grant", i), 64'(grant_id), 64'(tbl[i].gid));
      chk($sformatf("vec%0d.locked", i), 64'(locked), 64'(tbl[i].lk));
      if (tbl[i].vld[0])
        chk($sformatf("vec%0d.slot0", i), 64'(fifo_data_in[W-1:0]), 64'(tbl[i].d0));
      @(negedge clk);
    end

    do_reset();
    for (int r = 0; r < R; r++) begin
      have[r] = 1'b0; bcnt[r] = 0; bdat[r] = '0;
    end
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < R; r++) begin
        if (!have[r] && $urandom_range(0, 1) == 1) begin
          have[r] = 1'b1;
          bcnt[r] = $urandom_range(0, P);
          for (int k = 0; k < P; k++) bdat[r][k*W +: W] = $urandom();
        end
        if (m_lock != 0 && m_gr == r && have[r] && $urandom_range(0, 19) == 0) have[r] = 1'b0;
        req_valid[r] = have[r];
        for (int e = 0; e < P; e++) req_mask[r*P + e] = (e < bcnt[r]);
        req_data[r*P*W +: P*W] = bdat[r];
      end
      en_cnt = $urandom_range(0, P);
      for (int k = 0; k < P; k++) fifo_data_in_enable[k] = (k < en_cnt);
      fifo_full = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      #1;
      model_eval();
      chk($sformatf("rnd%0d.push", c), 64'(fifo_push), 64'(e_push));
      chk($sformatf("rnd%0d.valid", c), 64'(fifo_data_in_valid), 64'(e_vld));
      chk($sformatf("rnd%0d.accept", c), 64'(req_accept), 64'(e_acc));
      chk($sformatf("rnd%0d.done", c), 64'(req_done), 64'(e_done));
      chk($sformatf("rnd%0d.grant", c), 64'(grant_id), 64'(e_gid));
      chk($sformatf("rnd%0d.locked", c), 64'(locked), 64'(e_lk));
      for (int k = 0; k < e_n; k++)
        chk($sformatf("rnd%0d.slot%0d", c, k), 64'(fifo_data_in[k*W +: W]),
            64'(req_data[(e_sel*P + m_off + k)*W +: W]));
      for (int r = 0; r < R; r++)
        if (e_done[r]) have[r] = 1'b0;
      model_commit();
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
